idft16_seq: RTL and testbench
=============================

# idft16_seq

Sequential 16-point inverse DFT, the return path for the 16-point forward DFT datapath. It accepts 16 complex frequency bins as a stream and computes x[n] = (1/16)·Σk X[k]·e^(+j2πkn/16) with one complex MAC per cycle. It then streams out 16 complex time samples. Arithmetic is fixed-point only, so the block is synthesizable, unlike the real-valued forward model.

## Interface
- IN_W, 16: signed width of each input bin component (re, im).
- OUT_W, 16: signed width of each output sample component; results saturate to this width.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input bin present.
- in_ready  output  1  block accepts a bin; high only in LOAD.
- in_re, in_im  input  IN_W each  bin X[k], signed; bins arrive in order k = 0..15.
- out_valid  output  1  output sample present.
- out_ready  input  1  consumer accepts sample.
- out_re, out_im  output  OUT_W each  sample x[n], signed.
- out_index  output  4  n of the presented sample.
- busy  output  1  high in CALC or OUT.

## Operation
- Storage: a 16-entry bin RAM/register file holding IN_W re and IN_W im per entry.
- Twiddle ROM: cos table over m = 0..15, Q2.14. m = 0..4 gives 16384, 15137, 11585, 6270, 0; the rest follows by symmetry. sin(m) = cos((m−4) mod 16).
- States: LOAD, CALC, OUT.
- LOAD:
  - in_ready = 1.
  - Each in_valid & in_ready edge writes bin k and increments k.
  - The handshake on k = 15 moves to CALC, with n = 0, k = 0 and acc cleared.
- CALC, one cycle per k:
  - m = (k·n) mod 16, the natural 4-bit wrap of the product's low bits.
  - acc_re += Xr·c − Xi·s.
  - acc_im += Xr·s + Xi·c.
  - Accumulator width is IN_W + 16 + 1 + 4; it never wraps.
  - On the k = 15 edge, the final sum is rounded and registered into out_re and out_im. Then out_valid = 1, out_index = n, and the state moves to OUT.
- Scaling: result = (acc + 2^17) >>> 18. This is the 14 twiddle fraction bits plus the 4 bits of the 1/16 factor, rounding half toward +∞. The result then saturates to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- OUT: out_re, out_im and out_index stay stable while out_valid = 1 and out_ready = 0.
  - Handshake with n < 15: out_valid = 0, n increments, acc clears, k = 0, state returns to CALC.
  - Handshake with n = 15: state returns to LOAD.
- Input rule: in_valid outside LOAD is ignored; no bin is written and no error is flagged.

## Timing
- Reset values:
  - State LOAD, k = 0, n = 0, acc = 0.
  - out_valid = 0, out_re = 0, out_im = 0, out_index = 0, busy = 0.
  - in_ready = 1 from the first cycle after rst deasserts.
- Load: at least 16 cycles; gaps in in_valid stall k.
- Latency: out_valid rises in the cycle after the 16th rising edge following the edge that accepts bin 15. Subsequent samples follow the same 16-cycle CALC after each output handshake.
- Throughput with out_ready held at 1:
  - 16 + 16·17 = 288 cycles per frame.
  - in_ready is high again in the cycle after the n = 15 handshake.
- rst during any state:
  - Next cycle the block is in LOAD with reset values.
  - A partial frame is discarded. Bin RAM contents need not clear, but they are never used before being rewritten.
- rst and a handshake on the same edge: reset wins and the handshake is lost.

## Test plan
- Impulse: X[0] = (16,0), other bins 0, out_ready = 1 → 16 samples with (1,0), out_index 0..15, first out_valid exactly 16 edges after the bin-15 accept.
- Single tone: X[1] = (1600,0), other bins 0 → the following exact samples:
  - n = 0: (100, 0).
  - n = 1: (92, 38).
  - n = 4: (0, 100).
  - n = 8: (−100, 0).
  - n = 12: (0, −100).
- Round trip: feed bins from the forward transform of 1,2,…,8,0,…,0, quantized to integers ×16 → out_re ≈ 16·x[n] within ±1 LSB, and out_im within ±1 of 0.
- Saturation with OUT_W = 8: X[0] = (32767,0), other bins 0 → every sample is (127,0). With X[0] = (−32768,0) → every sample is (−128,0).
- Backpressure: out_ready low for 5 cycles at n = 3 → out_re, out_im and out_index are held constant. No sample is skipped or duplicated. in_valid pulses during CALC and OUT do not change results.
- Mid-frame reset:
  - Assert rst after bin 9 → no out_valid appears, and in_ready = 1 the cycle after release.
  - Then load a full impulse frame → the correct impulse result.
  - Repeat with rst asserted during OUT at n = 7.

Source files
------------

// File: rtl/idft16_seq.sv
// idft16_seq: sequential 16-point inverse DFT.
// Loads 16 complex bins, then for each output sample n runs 16 MAC cycles
// over k with Q2.14 twiddles. The sum is rounded (1/16 and twiddle scaling
// folded into one >>>18), saturated to OUT_W and presented on a
// valid/ready port.
//
// Handshake rule for both ports: a transfer happens on a rising edge where
// valid and ready are both high. The producer holds data stable while valid
// is high and ready is low. in_ready is high exactly while the block is in
// LOAD. out_valid stays high until the consumer takes the sample.
module idft16_seq #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic [3:0]              out_index,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int PROD_W = IN_W + 16;
  localparam int ACC_W  = IN_W + 16 + 1 + 4;
  localparam int EXT_W  = ACC_W - PROD_W;

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(131072);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                k_q, k_d;
  logic [3:0]                n_q, n_d;
  logic signed [ACC_W-1:0]   acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0]   acc_im_q, acc_im_d;
  logic signed [OUT_W-1:0]   out_re_q, out_re_d;
  logic signed [OUT_W-1:0]   out_im_q, out_im_d;
  logic [3:0]                out_idx_q, out_idx_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [IN_W-1:0]    bin_re_q [0:15];
  logic signed [IN_W-1:0]    bin_im_q [0:15];

  logic                      load_fire;
  logic [3:0]                m;
  logic signed [15:0]        cos_w, sin_w;
  logic signed [IN_W-1:0]    xr, xi;
  logic signed [PROD_W-1:0]  p_rc, p_is, p_rs, p_ic;
  logic signed [ACC_W-1:0]   term_re, term_im;
  logic signed [ACC_W-1:0]   acc_nxt_re, acc_nxt_im;
  logic signed [ACC_W-1:0]   scaled_re, scaled_im;

  // Quarter-wave symmetric cosine table, Q2.14, angle 2*pi*idx/16.
  function automatic logic signed [15:0] cos_lut(input logic [3:0] idx);
    logic signed [15:0] v;
    case (idx)
      4'd0:    v = 16'sd16384;
      4'd1:    v = 16'sd15137;
      4'd2:    v = 16'sd11585;
      4'd3:    v = 16'sd6270;
      4'd4:    v = 16'sd0;
      4'd5:    v = -16'sd6270;
      4'd6:    v = -16'sd11585;
      4'd7:    v = -16'sd15137;
      4'd8:    v = -16'sd16384;
      4'd9:    v = -16'sd15137;
      4'd10:   v = -16'sd11585;
      4'd11:   v = -16'sd6270;
      4'd12:   v = 16'sd0;
      4'd13:   v = 16'sd6270;
      4'd14:   v = 16'sd11585;
      default: v = 16'sd15137;
    endcase
    return v;
  endfunction

  // Clamp a scaled accumulator value into the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > SAT_MAX)      r = {1'b0, {(OUT_W-1){1'b1}}};
    else if (v < SAT_MIN) r = {1'b1, {(OUT_W-1){1'b0}}};
    else                  r = v[OUT_W-1:0];
    return r;
  endfunction

  assign load_fire = (state_q == S_LOAD) && in_valid;

  // Bin storage: written only by accepted input handshakes.
  always_ff @(posedge clk) begin
    if (!rst && load_fire) begin
      bin_re_q[k_q] <= in_re;
      bin_im_q[k_q] <= in_im;
    end
  end

  // One complex MAC term for the current (k, n); the angle index wraps mod 16.
  always_comb begin
    m          = k_q * n_q;
    cos_w      = cos_lut(m);
    sin_w      = cos_lut(m - 4'd4);
    xr         = bin_re_q[k_q];
    xi         = bin_im_q[k_q];
    p_rc       = xr * cos_w;
    p_is       = xi * sin_w;
    p_rs       = xr * sin_w;
    p_ic       = xi * cos_w;
    term_re    = {{EXT_W{p_rc[PROD_W-1]}}, p_rc} - {{EXT_W{p_is[PROD_W-1]}}, p_is};
    term_im    = {{EXT_W{p_rs[PROD_W-1]}}, p_rs} + {{EXT_W{p_ic[PROD_W-1]}}, p_ic};
    acc_nxt_re = acc_re_q + term_re;
    acc_nxt_im = acc_im_q + term_im;
    scaled_re  = (acc_nxt_re + RND) >>> 18;
    scaled_im  = (acc_nxt_im + RND) >>> 18;
  end

  // Next-state logic: LOAD -> CALC (16 MACs) -> OUT -> CALC ... -> LOAD.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          k_d = k_q + 4'd1;
          if (k_q == 4'd15) begin
            state_d  = S_CALC;
            k_d      = 4'd0;
            n_d      = 4'd0;
            acc_re_d = '0;
            acc_im_d = '0;
          end
        end
      end
      S_CALC: begin
        acc_re_d = acc_nxt_re;
        acc_im_d = acc_nxt_im;
        k_d      = k_q + 4'd1;
        if (k_q == 4'd15) begin
          out_re_d    = sat_out(scaled_re);
          out_im_d    = sat_out(scaled_im);
          out_idx_d   = n_q;
          out_valid_d = 1'b1;
          k_d         = 4'd0;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          k_d         = 4'd0;
          acc_re_d    = '0;
          acc_im_d    = '0;
          if (n_q == 4'd15) begin
            n_d     = 4'd0;
            state_d = S_LOAD;
          end else begin
            n_d     = n_q + 4'd1;
            state_d = S_CALC;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      k_q         <= 4'd0;
      n_q         <= 4'd0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_CALC) || (state_q == S_OUT);
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_index = out_idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_idft16_seq.sv
// Bench for idft16_seq: a 16-bit and an 8-bit output instance share one
// stimulus stream; a real-arithmetic IDFT model fills the expected queue.
module tb_idft16_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                in_valid;
  logic signed [15:0]  in_re, in_im;
  logic                out_ready;

  logic                in_ready, out_valid, busy;
  logic signed [15:0]  out_re, out_im;
  logic [3:0]          out_index;
  logic [1:0]          dbg_state;

  logic                in_ready8, out_valid8, busy8;
  logic signed [7:0]   out_re8, out_im8;
  logic [3:0]          out_index8;
  logic [1:0]          dbg_state8;

  idft16_seq #(.IN_W(16), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_index(out_index), .busy(busy),
    .dbg_state(dbg_state)
  );

  idft16_seq #(.IN_W(16), .OUT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid8), .out_ready(out_ready),
    .out_re(out_re8), .out_im(out_im8), .out_index(out_index8), .busy(busy8),
    .dbg_state(dbg_state8)
  );

  // ---------------- scoreboard state ----------------
  localparam int W = 52;  // {idx4, re16, im16, re8, im8}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  int err_cnt = 0;
  int chk_cnt = 0;

  int cos_tab[16], sin_tab[16];
  int bin_re[16], bin_im[16];
  int got_re16[16], got_im16[16], got_re8[16], got_im8[16];

  int  rdy_mode;
  int  stall_left;
  int  stalls_seen;
  bit  noise_en;

  bit               prev_stall;
  logic signed [15:0] h_re, h_im;
  logic [3:0]       h_idx;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rnd_real(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic int sat(input longint v, input int w);
    longint lim;
    lim = longint'(1) << (w - 1);
    if (v > lim - 1) return int'(lim - 1);
    if (v < -lim)    return int'(-lim);
    return int'(v);
  endfunction

  // x[n] = (1/16) sum_k X[k] e^{+j2pi kn/16}, with Q2.14 twiddles and
  // round-half-up scaling; pushes all 16 expected samples of the frame.
  task automatic push_model();
    longint ar, ai, rr, ri;
    int m;
    logic [W-1:0] e;
    for (int n = 0; n < 16; n++) begin
      got_re16[n] = -9999; got_im16[n] = -9999;
      got_re8[n]  = -9999; got_im8[n]  = -9999;
      ar = 0; ai = 0;
      for (int k = 0; k < 16; k++) begin
        m  = (k * n) % 16;
        ar += longint'(bin_re[k]) * cos_tab[m] - longint'(bin_im[k]) * sin_tab[m];
        ai += longint'(bin_re[k]) * sin_tab[m] + longint'(bin_im[k]) * cos_tab[m];
      end
      rr = (ar + 131072) >>> 18;
      ri = (ai + 131072) >>> 18;
      e = {4'(n), 16'(sat(rr, 16)), 16'(sat(ri, 16)), 8'(sat(rr, 8)), 8'(sat(ri, 8))};
      exp_q.push_back(e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bins(input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          in_re = 16'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_re    = 16'(bin_re[i]);
      in_im    = 16'(bin_im[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || !in_ready) && cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_eq("frame_done", (cnt < 5000) ? 1 : 0, 1);
    noise_en = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic clear_bins();
    for (int k = 0; k < 16; k++) begin
      bin_re[k] = 0;
      bin_im[k] = 0;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic impulse_frame(input string tag);
    clear_bins();
    bin_re[0] = 16;
    push_model();
    drive_bins(16, 1'b1);
    wait_done();
    for (int n = 0; n < 16; n++) begin
      check_eq({tag, "_re"}, got_re16[n], 1);
      check_eq({tag, "_im"}, got_im16[n], 0);
    end
  endtask

  // ---------------- consumer (out_ready) ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: out_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (out_valid && out_index == 4'd3 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        3: out_ready = !(out_valid && out_index == 4'd7);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- in_valid noise while busy ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (noise_en) begin
        if (busy) begin
          in_valid = 1'($urandom_range(0, 1));
          in_re    = 16'($urandom);
          in_im    = 16'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", out_valid, 1);
          check_eq("hold_re", out_re, h_re);
          check_eq("hold_im", out_im, h_im);
          check_eq("hold_idx", out_index, h_idx);
        end
        if (out_valid && !out_ready) stalls_seen++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_out", out_index, -1);
          end else begin
            mon_e = exp_q.pop_front();
            check_eq("out_index", out_index, mon_e[51:48]);
            check_eq("out_re16", out_re, $signed(mon_e[47:32]));
            check_eq("out_im16", out_im, $signed(mon_e[31:16]));
            check_eq("out_valid8", out_valid8, 1);
            check_eq("out_re8", out_re8, $signed(mon_e[15:8]));
            check_eq("out_im8", out_im8, $signed(mon_e[7:0]));
            got_re16[out_index] = out_re;
            got_im16[out_index] = out_im;
            got_re8[out_index]  = out_re8;
            got_im8[out_index]  = out_im8;
          end
        end
        prev_stall = out_valid && !out_ready;
        h_re  = out_re;
        h_im  = out_im;
        h_idx = out_index;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", err_cnt + 1, chk_cnt + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  int  lat, cnt, ov_cnt, found;
  real xs[16];
  real sr, si;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
    rdy_mode = 0; stall_left = 0; stalls_seen = 0; noise_en = 1'b0;
    for (int m = 0; m < 16; m++) begin
      cos_tab[m] = rnd_real(16384.0 * $cos(2.0 * 3.14159265358979 * m / 16.0));
      sin_tab[m] = rnd_real(16384.0 * $sin(2.0 * 3.14159265358979 * m / 16.0));
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_re", out_re, 0);
    check_eq("rst_out_im", out_im, 0);
    check_eq("rst_out_index", out_index, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid8", out_valid8, 0);

    // Impulse with latency and frame-length measurement.
    clear_bins();
    bin_re[0] = 16;
    push_model();
    drive_bins(16, 1'b0);
    cnt = 0; lat = -1;
    do begin
      @(posedge clk); #1;
      cnt++;
      if (out_valid && lat < 0) lat = cnt;
    end while (!in_ready && cnt < 1000);
    check_eq("impulse_latency", lat, 16);
    check_eq("frame_cycles", cnt, 272);
    wait_done();
    for (int n = 0; n < 16; n++) begin
      check_eq("impulse_re", got_re16[n], 1);
      check_eq("impulse_im", got_im16[n], 0);
    end

    // Single tone at k = 1.
    clear_bins();
    bin_re[1] = 1600;
    push_model();
    drive_bins(16, 1'b1);
    wait_done();
    check_eq("tone_n0_re", got_re16[0], 100);
    check_eq("tone_n0_im", got_im16[0], 0);
    check_eq("tone_n1_re", got_re16[1], 92);
    check_eq("tone_n1_im", got_im16[1], 38);
    check_eq("tone_n4_re", got_re16[4], 0);
    check_eq("tone_n4_im", got_im16[4], 100);
    check_eq("tone_n8_re", got_re16[8], -100);
    check_eq("tone_n8_im", got_im16[8], 0);
    check_eq("tone_n12_re", got_re16[12], 0);
    check_eq("tone_n12_im", got_im16[12], -100);

    // Round trip of 1..8,0..0 through a forward DFT scaled by 16.
    for (int n = 0; n < 16; n++) xs[n] = (n < 8) ? real'(n + 1) : 0.0;
    for (int k = 0; k < 16; k++) begin
      sr = 0.0; si = 0.0;
      for (int n = 0; n < 16; n++) begin
        sr += xs[n] * $cos(2.0 * 3.14159265358979 * k * n / 16.0);
        si -= xs[n] * $sin(2.0 * 3.14159265358979 * k * n / 16.0);
      end
      bin_re[k] = rnd_real(16.0 * sr);
      bin_im[k] = rnd_real(16.0 * si);
    end
    push_model();
    drive_bins(16, 1'b1);
    wait_done();
    for (int n = 0; n < 16; n++) begin
      cnt = got_re16[n] - rnd_real(16.0 * xs[n]);
      check_eq("rt_re_tol", (cnt >= -1 && cnt <= 1) ? 1 : 0, 1);
      check_eq("rt_im_tol", (got_im16[n] >= -1 && got_im16[n] <= 1) ? 1 : 0, 1);
    end

    // Saturation on the 8-bit instance.
    clear_bins();
    bin_re[0] = 32767;
    push_model();
    drive_bins(16, 1'b0);
    wait_done();
    for (int n = 0; n < 16; n++) begin
      check_eq("sat_pos_re8", got_re8[n], 127);
      check_eq("sat_pos_im8", got_im8[n], 0);
    end
    clear_bins();
    bin_re[0] = -32768;
    push_model();
    drive_bins(16, 1'b0);
    wait_done();
    for (int n = 0; n < 16; n++) begin
      check_eq("sat_neg_re8", got_re8[n], -128);
      check_eq("sat_neg_im8", got_im8[n], 0);
    end

    // Backpressure: 5 stall cycles at n = 3, with in_valid noise while busy.
    for (int k = 0; k < 16; k++) begin
      bin_re[k] = $signed(16'($urandom));
      bin_im[k] = $signed(16'($urandom));
    end
    push_model();
    rdy_mode = 2; stall_left = 5; stalls_seen = 0;
    drive_bins(16, 1'b1);
    noise_en = 1'b1;
    wait_done();
    check_eq("bp_stall_cycles", stalls_seen, 5);
    rdy_mode = 0;

    // Random frames with random backpressure and noise.
    rdy_mode = 1;
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 16; k++) begin
        bin_re[k] = $signed(16'($urandom));
        bin_im[k] = (f == 0) ? 0 : $signed(16'($urandom_range(0, 65535)));
      end
      push_model();
      drive_bins(16, 1'b1);
      noise_en = 1'b1;
      wait_done();
    end
    rdy_mode = 0;

    // Reset after bin 9: partial frame discarded.
    clear_bins();
    drive_bins(10, 1'b0);
    pulse_reset();
    @(negedge clk);
    check_eq("rst_mid_in_ready", in_ready, 1);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_out_valid", out_valid, 0);
    ov_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    check_eq("rst_mid_no_output", ov_cnt, 0);
    @(posedge clk); #1;
    impulse_frame("rst_mid_impulse");

    // Reset while sample n = 7 is held in OUT.
    for (int k = 0; k < 16; k++) begin
      bin_re[k] = $signed(16'($urandom));
      bin_im[k] = $signed(16'($urandom));
    end
    push_model();
    rdy_mode = 3;
    drive_bins(16, 1'b0);
    found = 0; cnt = 0;
    while (!found && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (out_valid && out_index == 4'd7) found = 1;
    end
    check_eq("rst_out_reach_n7", found, 1);
    check_eq("rst_out_remaining", exp_q.size(), 9);
    @(posedge clk); #1;
    pulse_reset();
    exp_q.delete();
    rdy_mode = 0;
    @(negedge clk);
    check_eq("rst_out_valid_clr", out_valid, 0);
    check_eq("rst_out_index_clr", out_index, 0);
    check_eq("rst_out_re_clr", out_re, 0);
    check_eq("rst_out_in_ready", in_ready, 1);
    check_eq("rst_out_busy", busy, 0);
    ov_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    check_eq("rst_out_no_output", ov_cnt, 0);
    @(posedge clk); #1;
    impulse_frame("rst_out_impulse");

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
